gray4_expander: RTL and testbench
=================================

Name: gray4_expander

Overview:
Inverse of the 4-bit quantisation path. Accepts packed 16-bit words (4 pixels × 4 bpp, pixel 0 in bits [15:12]) and expands each nibble to 8 bpp through a programmable 16-entry LUT. Emits packed 32-bit words (pixel 0 in bits [31:24]) with line and frame markers. Used for readback/compare of dithered framebuffer content and for host-side preview. Valid/ready on both sides, with a skid buffer so that s_ready is registered.

Parameters:
H_WORDS, 400, words per line (4 pixels per word); range 2..4095
V_LINES, 1200, lines per frame; range 2..4095

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
s_valid  in  1  input word valid
s_ready  out  1  input ready (registered)
s_data  in  16  packed 4-bpp pixels, [15:12]=pixel 0 … [3:0]=pixel 3
s_sof  in  1  qualifies s_data as first word of a frame
m_valid  out  1  output word valid
m_ready  in  1  downstream ready
m_data  out  32  packed 8-bpp pixels, [31:24]=pixel 0 … [7:0]=pixel 3
m_eol  out  1  m_data is last word of a line
m_eof  out  1  m_data is last word of a frame (m_eol also high)
cfg_we  in  1  LUT write strobe
cfg_addr  in  4  LUT entry index
cfg_data  in  8  LUT entry value

Behaviour:
- Reset values: s_ready=1, m_valid=0, m_data=0, m_eol=0, m_eof=0, col=0, line=0, skid empty.
- Reset also loads LUT[i] = i*17 (0x00, 0x11 … 0xFF), i.e. nibble replicated into both halves.
- Reset asserted mid-stream discards any buffered words. There is no partial output after reset.
- Accept: an input word is accepted when s_valid && s_ready.
- Lookup happens in the accept cycle. Output byte k = LUT[nibble k].
- Latency: the result is in the output register with m_valid=1 on the cycle after acceptance.
- Output register loads when it is empty or m_ready=1.
- Skid buffer: if the output register is full and m_ready=0 in an accept cycle, the expanded word goes to the skid register.
- s_ready deasserts the following cycle while the skid register is occupied.
- When the output register drains (m_ready=1), the skid contents move to the output register. s_ready returns to 1 on the next cycle.
- Throughput: with m_ready held high, one word per cycle sustained.
- Output ordering: no word is ever dropped or duplicated.
- m_data, m_eol and m_eof hold stable while m_valid && !m_ready.
- Position counters advance per accepted word:
  - If s_sof=1, the word is tagged col=0, line=0.
  - Otherwise the word takes the current counters.
  - Next counters: col+1. At col==H_WORDS-1, col wraps to 0 and line+1.
  - At line==V_LINES-1 with col==H_WORDS-1, both counters wrap to 0.
- Markers: m_eol = (tag col == H_WORDS-1). m_eof = m_eol && (tag line == V_LINES-1). Markers travel with their data through the skid buffer.
- s_sof arriving mid-line resynchronises the counters immediately. The prior partial line gets no m_eol.
- LUT write: on a cfg_we cycle, LUT[cfg_addr] <= cfg_data.
- A word accepted in the same cycle as a write uses the old entry. Words accepted from the next cycle on use the new entry.
- Words already buffered are not re-mapped.
- Widths: all LUT values are 8-bit. No arithmetic saturation is needed.

Test Plan:
1. Reset, m_ready=1, send s_data=0x0F5A with s_sof=1 → next cycle m_valid=1, m_data=0x00FF55AA, m_eol=0, m_eof=0.
2. H_WORDS=2, V_LINES=2, stream 4 words with s_sof on the first → m_eol on words 2 and 4, m_eof only on word 4. A 5th word without s_sof is tagged col=0/line=0.
3. Stream 8 words at 1/cycle; hold m_ready=0 for 3 cycles mid-stream → s_ready drops one cycle after the stall begins. All 8 words emerge in order with no loss. m_data is stable while stalled.
4. Write cfg_addr=0x3, cfg_data=0x40 in the same cycle as accepting 0x3333, then accept 0x3333 again → outputs 0x33333333, then 0x40404040.
5. Fill output and skid, pulse rst for one cycle → m_valid=0 and s_ready=1 next cycle. LUT is restored: 0x3333 → 0x33333333.
6. Random valid/ready toggling over 2 frames (H_WORDS=4, V_LINES=3) against a scoreboard → the byte stream and marker positions exactly match the model.

Source files
------------

// File: rtl/gray4_expander.sv
// gray4_expander: expands packed 4-bpp words to packed 8-bpp words via a
// programmable 16-entry LUT. Each output word carries line/frame end markers.
// The output register is backed by a one-entry skid buffer, so s_ready is a flop.
module gray4_expander #(
    parameter int H_WORDS = 400,
    parameter int V_LINES = 1200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        s_sof,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_eol,
    output logic        m_eof,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [7:0]  cfg_data
);
    localparam int CW = $clog2(H_WORDS);
    localparam int LW = $clog2(V_LINES);

    logic [7:0]    lut_q [16];
    logic [CW-1:0] col_q, col_d, col_tag;
    logic [LW-1:0] line_q, line_d, line_tag;
    logic          tag_eol, tag_eof;
    logic          accept;
    logic [31:0]   exp_word;

    logic          s_ready_q;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   m_data_q, m_data_d;
    logic          m_eol_q, m_eol_d, m_eof_q, m_eof_d;
    logic          skid_valid_q, skid_valid_d;
    logic [31:0]   skid_data_q, skid_data_d;
    logic          skid_eol_q, skid_eol_d, skid_eof_q, skid_eof_d;

    assign accept   = s_valid && s_ready_q;
    // Lookup reads the registered LUT, so a same-cycle write is seen only from the next word on.
    assign exp_word = {lut_q[s_data[15:12]], lut_q[s_data[11:8]],
                       lut_q[s_data[7:4]],   lut_q[s_data[3:0]]};

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_eol   = m_eol_q;
    assign m_eof   = m_eof_q;

    // Position tagging of the incoming word and next-position counters.
    always_comb begin
        col_tag  = s_sof ? '0 : col_q;
        line_tag = s_sof ? '0 : line_q;
        tag_eol  = (col_tag == CW'(H_WORDS - 1));
        tag_eof  = tag_eol && (line_tag == LW'(V_LINES - 1));
        col_d    = col_q;
        line_d   = line_q;
        if (accept) begin
            if (tag_eol) begin
                col_d  = '0;
                line_d = tag_eof ? '0 : line_tag + 1'b1;
            end else begin
                col_d  = col_tag + 1'b1;
                line_d = line_tag;
            end
        end
    end

    // Output register / skid buffer steering.
    always_comb begin
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_eol_d      = m_eol_q;
        m_eof_d      = m_eof_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_eol_d   = skid_eol_q;
        skid_eof_d   = skid_eof_q;
        if (m_valid_q && !m_ready) begin
            // Output is stalled; a word accepted now can only be parked in the skid.
            if (accept) begin
                skid_valid_d = 1'b1;
                skid_data_d  = exp_word;
                skid_eol_d   = tag_eol;
                skid_eof_d   = tag_eof;
            end
        end else if (skid_valid_q) begin
            // s_ready is low while the skid is full, so no accept competes here.
            m_valid_d    = 1'b1;
            m_data_d     = skid_data_q;
            m_eol_d      = skid_eol_q;
            m_eof_d      = skid_eof_q;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = exp_word;
            m_eol_d   = tag_eol;
            m_eof_d   = tag_eof;
        end else begin
            m_valid_d = 1'b0;
        end
    end

    // LUT storage: identity-like ramp (nibble replicated) after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) lut_q[i] <= 8'(i * 17);
        end else if (cfg_we) begin
            lut_q[cfg_addr] <= cfg_data;
        end
    end

    // Datapath, counter and handshake state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            line_q       <= '0;
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_eol_q      <= 1'b0;
            m_eof_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_eol_q   <= 1'b0;
            skid_eof_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            line_q       <= line_d;
            s_ready_q    <= !skid_valid_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_eol_q      <= m_eol_d;
            m_eof_q      <= m_eof_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_eol_q   <= skid_eol_d;
            skid_eof_q   <= skid_eof_d;
        end
    end
endmodule

// File: tb/tb_gray4_expander.sv
// Bench for gray4_expander: two instances (2x2 and 4x3 geometry) share one stimulus.
module tb_gray4_expander;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, s_valid, s_sof, m_ready, cfg_we;
    logic [15:0] s_data;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        s_ready_a, m_valid_a, m_eol_a, m_eof_a;
    logic        s_ready_b, m_valid_b, m_eol_b, m_eof_b;
    logic [31:0] m_data_a, m_data_b;

    gray4_expander #(.H_WORDS(2), .V_LINES(2)) dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
        .s_sof(s_sof), .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
        .m_eol(m_eol_a), .m_eof(m_eof_a), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data));

    gray4_expander #(.H_WORDS(4), .V_LINES(3)) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
        .s_sof(s_sof), .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
        .m_eol(m_eol_b), .m_eof(m_eof_b), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data));

    typedef struct packed {
        logic [31:0] data;
        logic        eol_a, eof_a, eol_b, eof_b;
    } exp_t;

    typedef struct packed {
        logic [15:0] d;
        logic        sof;
        logic [31:0] exp;
        logic [3:0]  mk;
    } vec_t;

    exp_t       q[$];
    vec_t       tv [8];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] lut_m [16];
    int         col_a, line_a, col_b, line_b;
    logic       mon_en = 1'b0;
    int         idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) lut_m[i] = 8'(i * 17);
        col_a = 0; line_a = 0; col_b = 0; line_b = 0;
        q.delete();
    endfunction

    function automatic void model_accept(input logic [15:0] d, input logic sof);
        exp_t e;
        int ca, la, cb, lb;
        e.data = {lut_m[d[15:12]], lut_m[d[11:8]], lut_m[d[7:4]], lut_m[d[3:0]]};
        ca = sof ? 0 : col_a;  la = sof ? 0 : line_a;
        cb = sof ? 0 : col_b;  lb = sof ? 0 : line_b;
        e.eol_a = (ca == 1);
        e.eof_a = e.eol_a && (la == 1);
        e.eol_b = (cb == 3);
        e.eof_b = e.eol_b && (lb == 2);
        if (ca == 1) begin col_a = 0; line_a = (la == 1) ? 0 : la + 1; end
        else begin col_a = ca + 1; line_a = la; end
        if (cb == 3) begin col_b = 0; line_b = (lb == 2) ? 0 : lb + 1; end
        else begin col_b = cb + 1; line_b = lb; end
        q.push_back(e);
    endfunction

    // Scoreboard monitor: compares the head of the queue whenever a word is presented.
    always @(negedge clk) begin
        if (mon_en && !rst && m_valid_a) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_word actual=%h required=none", m_data_a);
            end else begin
                chk("sb_data_a", m_data_a, q[0].data);
                chk("sb_data_b", m_data_b, q[0].data);
                chk("sb_markers", {m_eol_a, m_eof_a, m_eol_b, m_eof_b},
                    {q[0].eol_a, q[0].eof_a, q[0].eol_b, q[0].eof_b});
                chk("sb_valid_b", m_valid_b, 1);
                if (m_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        // {s_data, s_sof, expected m_data, {eol_a, eof_a, eol_b, eof_b}} with default LUT
        tv[0] = '{16'h0F5A, 1'b1, 32'h00FF55AA, 4'b0000};
        tv[1] = '{16'h1234, 1'b0, 32'h11223344, 4'b1000};
        tv[2] = '{16'h5678, 1'b0, 32'h55667788, 4'b0000};
        tv[3] = '{16'h9ABC, 1'b0, 32'h99AABBCC, 4'b1110};
        tv[4] = '{16'hDEF0, 1'b0, 32'hDDEEFF00, 4'b0000};
        tv[5] = '{16'hFFFF, 1'b0, 32'hFFFFFFFF, 4'b1000};
        tv[6] = '{16'h0001, 1'b1, 32'h00000011, 4'b0000};
        tv[7] = '{16'h2222, 1'b0, 32'h22222222, 4'b1000};

        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        cyc(); cyc();
        chk("rst_m_valid", m_valid_a, 0);
        chk("rst_s_ready", s_ready_a, 1);
        chk("rst_m_data", m_data_a, 0);
        chk("rst_markers", {m_eol_a, m_eof_a, m_eol_b, m_eof_b}, 0);
        rst = 1'b0;
        cyc();

        // Back-to-back table vectors, one per cycle with m_ready held high.
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = tv[i].d; s_sof = tv[i].sof;
            chk($sformatf("tbl%0d_s_ready", i), s_ready_a, 1);
            chk($sformatf("tbl%0d_s_ready_b", i), s_ready_b, 1);
            cyc();
            chk($sformatf("tbl%0d_valid", i), m_valid_a, 1);
            chk($sformatf("tbl%0d_data", i), m_data_a, tv[i].exp);
            chk($sformatf("tbl%0d_markers", i), {m_eol_a, m_eof_a, m_eol_b, m_eof_b}, tv[i].mk);
        end
        s_valid = 1'b0; s_sof = 1'b0;
        cyc();
        chk("idle_m_valid", m_valid_a, 0);

        // LUT write in the same cycle as an accept uses the old entry.
        s_valid = 1'b1; s_data = 16'h3333; cfg_we = 1'b1; cfg_addr = 4'h3; cfg_data = 8'h40;
        cyc();
        cfg_we = 1'b0;
        chk("lut_old_entry", m_data_a, 32'h33333333);
        cyc();
        s_valid = 1'b0;
        chk("lut_new_entry", m_data_a, 32'h40404040);

        // Fill output and skid, then reset.
        m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h1111;
        cyc();
        s_data = 16'h2222;
        cyc();
        s_valid = 1'b0;
        chk("full_s_ready_low", s_ready_a, 0);
        chk("full_m_valid", m_valid_a, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_m_valid", m_valid_a, 0);
        chk("midrst_s_ready", s_ready_a, 1);
        m_ready = 1'b1; s_valid = 1'b1; s_data = 16'h3333;
        cyc();
        s_valid = 1'b0;
        chk("midrst_lut_restored", m_data_a, 32'h33333333);
        cyc();

        // Stall of 3 cycles in the middle of an 8-word burst.
        model_reset();
        mon_en = 1'b1;
        idx = 0;
        for (int c = 0; c < 40 && (idx < 8 || q.size() != 0); c++) begin
            m_ready = !(c >= 3 && c < 6);
            s_valid = (idx < 8);
            s_data  = 16'((idx * 16'h1357) ^ 16'hA5C3);
            s_sof   = (idx == 0);
            if (c == 4) chk("stall_s_ready_low", s_ready_a, 0);
            if (c == 6) chk("stall_s_ready_still_low", s_ready_a, 0);
            if (c == 7) chk("stall_s_ready_back", s_ready_a, 1);
            if (s_valid && s_ready_a) begin
                model_accept(s_data, s_sof);
                idx++;
            end
            cyc();
        end
        s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
        chk("stall_words_sent", idx, 8);
        chk("stall_queue_drained", q.size(), 0);
        cyc();

        // Random valid/ready and occasional LUT writes over several frames.
        idx = 0;
        for (int c = 0; c < 3000 && (idx < 30 || q.size() != 0); c++) begin
            m_ready  = (idx >= 30) ? 1'b1 : ($urandom_range(0, 3) != 0);
            s_valid  = (idx < 30) && ($urandom_range(0, 2) != 0);
            s_data   = 16'($urandom);
            s_sof    = s_valid && (idx == 0 || idx == 12);
            cfg_we   = ($urandom_range(0, 15) == 0);
            cfg_addr = 4'($urandom);
            cfg_data = 8'($urandom);
            if (s_valid && s_ready_a) begin
                model_accept(s_data, s_sof);
                idx++;
            end
            if (cfg_we) lut_m[cfg_addr] = cfg_data;
            cyc();
        end
        s_valid = 1'b0; s_sof = 1'b0; cfg_we = 1'b0;
        chk("rand_words_sent", idx, 30);
        chk("rand_queue_drained", q.size(), 0);
        cyc();
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
